// File: rtl/weight_pattern_generator.sv
// Enumerates every WID_Pattern-bit word of a requested popcount in increasing order,
// one word per valid/ready transfer, using a divider-free Gosper successor.
module weight_pattern_generator #(
    parameter int WID_Pattern = 8,
    parameter int WID_Weight  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   local_WG_start,
    input  logic [WID_Weight-1:0]  local_WG_weight,
    input  logic                   local_WG_abort,
    input  logic                   local_WG_ready,
    output logic                   WG_local_valid,
    output logic [WID_Pattern-1:0] WG_local_pattern,
    output logic                   WG_local_last,
    output logic                   WG_local_busy,
    output logic                   WG_local_error
);

    localparam int N   = WID_Pattern;
    localparam int TZW = $clog2(N + 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t         r_state;
    logic [N-1:0]   r_pattern;
    logic [N-1:0]   r_top;
    logic           r_valid;
    logic           r_last;
    logic           r_busy;
    logic           r_error;

    logic           w_weight_ok;
    logic [N-1:0]   w_first;
    logic [N-1:0]   w_top;
    logic [N:0]     w_x;
    logic [N:0]     w_low;
    logic [N:0]     w_ripple;
    logic [N-1:0]   w_ones;
    logic [N-1:0]   w_next;

    function automatic logic [TZW-1:0] f_tz(input logic [N:0] v);
        logic [TZW-1:0] n;
        n = '0;
        for (int i = N; i >= 0; i--) begin
            if (v[i]) n = TZW'(i);
        end
        return n;
    endfunction

    // First pattern is the W low bits; the final one is the same block shifted to the top.
    always_comb begin
        w_weight_ok = (int'(local_WG_weight) <= N);
        w_first     = '0;
        w_top       = '0;
        for (int i = 0; i < N; i++) begin
            w_first[i] = (i < int'(local_WG_weight));
            w_top[i]   = (i + int'(local_WG_weight) >= N);
        end
    end

    // Gosper successor: the division by the lowest set bit becomes a right shift by its index.
    always_comb begin
        w_x      = {1'b0, r_pattern};
        w_low    = w_x & (-w_x);
        w_ripple = w_x + w_low;
        w_ones   = N'(((w_ripple ^ w_x) >> 2) >> f_tz(w_low));
        w_next   = w_ripple[N-1:0] | w_ones;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_pattern <= '0;
            r_top     <= '0;
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
            r_busy    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_error <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (local_WG_start && !local_WG_abort) begin
                        if (w_weight_ok) begin
                            r_state   <= S_RUN;
                            r_pattern <= w_first;
                            r_top     <= w_top;
                            r_valid   <= 1'b1;
                            r_busy    <= 1'b1;
                            r_last    <= (w_first == w_top);
                        end else begin
                            r_error <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (local_WG_abort || (local_WG_ready && r_last)) begin
                        r_state   <= S_IDLE;
                        r_pattern <= '0;
                        r_valid   <= 1'b0;
                        r_busy    <= 1'b0;
                        r_last    <= 1'b0;
                    end else if (local_WG_ready) begin
                        r_pattern <= w_next;
                        r_last    <= (w_next == r_top);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign WG_local_valid   = r_valid;
    assign WG_local_pattern = r_pattern;
    assign WG_local_last    = r_last;
    assign WG_local_busy    = r_busy;
    assign WG_local_error   = r_error;

endmodule

// File: tb/tb_weight_pattern_generator.sv
// Bench for weight_pattern_generator: popcount-enumeration model plus directed scenarios.
module tb_weight_pattern_generator;

    localparam int N = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         start, abort, ready;
    logic [3:0]   weight;
    logic         valid, last, busy, error;
    logic [N-1:0] pattern;

    logic         start5, abort5, ready5;
    logic [2:0]   weight5;
    logic         valid5, last5, busy5, error5;
    logic [4:0]   pattern5;

    weight_pattern_generator #(.WID_Pattern(8), .WID_Weight(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .local_WG_start(start), .local_WG_weight(weight),
        .local_WG_abort(abort), .local_WG_ready(ready),
        .WG_local_valid(valid), .WG_local_pattern(pattern),
        .WG_local_last(last), .WG_local_busy(busy), .WG_local_error(error)
    );

    weight_pattern_generator #(.WID_Pattern(5), .WID_Weight(3)) dut5 (
        .clk(clk), .rst_n(rst_n),
        .local_WG_start(start5), .local_WG_weight(weight5),
        .local_WG_abort(abort5), .local_WG_ready(ready5),
        .WG_local_valid(valid5), .WG_local_pattern(pattern5),
        .WG_local_last(last5), .WG_local_busy(busy5), .WG_local_error(error5)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference model: the full ordered list of words with the requested popcount.
    logic [N-1:0] exp_q[$];
    logic [N-1:0] got_q[$];
    bit           m_active = 1'b0;
    bit           m_err    = 1'b0;
    int           m_idx    = 0;
    int           m_w      = 0;

    function automatic void build(input int w);
        logic [N-1:0] b;
        exp_q.delete();
        for (int v = 0; v < (1 << N); v++) begin
            b = N'(v);
            if ($countones(b) == w) exp_q.push_back(b);
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 1'b0;
            m_err    = 1'b0;
        end else begin
            m_err = 1'b0;
            if (!m_active) begin
                if (start && !abort) begin
                    if (int'(weight) > N) begin
                        m_err = 1'b1;
                    end else begin
                        build(int'(weight));
                        m_w      = int'(weight);
                        m_idx    = 0;
                        m_active = 1'b1;
                    end
                end
            end else if (abort) begin
                m_active = 1'b0;
            end else if (ready) begin
                if (m_idx == exp_q.size() - 1) m_active = 1'b0;
                else m_idx++;
            end
        end
    end

    always @(negedge clk) begin
        check("error", error, m_err);
        check("valid", valid, m_active);
        check("busy", busy, m_active);
        if (m_active) begin
            check("pattern", pattern, exp_q[m_idx]);
            check("last", last, (m_idx == exp_q.size() - 1));
            check("popcount", $countones(pattern), m_w);
            if (valid && ready && !abort) got_q.push_back(pattern);
        end else begin
            check("pattern_idle", pattern, 0);
            check("last_idle", last, 0);
        end
    end

    task automatic run_enum(input int w, input bit rnd);
        got_q.delete();
        weight = 4'(w);
        start  = 1'b1;
        tick;
        start  = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (!m_active) return;
            ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick;
        end
        check("enum_timeout", m_active, 0);
    endtask

    int exp5[6] = '{1, 5, 10, 10, 5, 1};

    initial begin
        int cnt, prev;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; ready = 1'b0; weight = '0;
        start5 = 1'b0; abort5 = 1'b0; ready5 = 1'b1; weight5 = '0;
        tick; tick;
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        check("rst_pattern", pattern, 0);
        check("rst_last", last, 0);
        check("rst_error", error, 0);
        rst_n = 1'b1;
        tick;

        build(2);
        check("model_len_w2", exp_q.size(), 28);
        check("model_w2_6", exp_q[6], 8'h11);
        build(3);
        check("model_len_w3", exp_q.size(), 56);

        run_enum(2, 1'b0);
        check("w2_count", got_q.size(), 28);
        check("w2_0", got_q[0], 8'h03);
        check("w2_1", got_q[1], 8'h05);
        check("w2_2", got_q[2], 8'h06);
        check("w2_3", got_q[3], 8'h09);
        check("w2_4", got_q[4], 8'h0A);
        check("w2_5", got_q[5], 8'h0C);
        check("w2_6", got_q[6], 8'h11);
        check("w2_26", got_q[26], 8'hA0);
        check("w2_27", got_q[27], 8'hC0);
        check("w2_busy_after", busy, 0);

        run_enum(0, 1'b0);
        check("w0_count", got_q.size(), 1);
        check("w0_pat", got_q[0], 8'h00);
        run_enum(8, 1'b0);
        check("w8_count", got_q.size(), 1);
        check("w8_pat", got_q[0], 8'hFF);

        weight = 4'd9; start = 1'b1;
        tick;
        start = 1'b0;
        check("w9_error", error, 1);
        check("w9_valid", valid, 0);
        check("w9_busy", busy, 0);
        tick;
        check("w9_error_drop", error, 0);
        check("w9_valid2", valid, 0);

        run_enum(3, 1'b1);
        check("w3_count", got_q.size(), 56);
        for (int i = 0; i < got_q.size(); i++) begin
            check("w3_pop", $countones(got_q[i]), 3);
            if (i > 0) check("w3_incr", got_q[i] > got_q[i-1], 1);
        end

        got_q.delete();
        weight = 4'd2; start = 1'b1;
        tick;
        start = 1'b0; ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (got_q.size() >= 5) break;
            tick;
        end
        check("abort_pre_count", got_q.size(), 5);
        abort = 1'b1; start = 1'b1; weight = 4'd5;
        tick;
        abort = 1'b0; start = 1'b0;
        check("abort_valid", valid, 0);
        check("abort_busy", busy, 0);
        check("abort_count", got_q.size(), 5);
        check("abort_last_xfer", got_q[4], 8'h0A);
        tick;
        check("abort_start_ignored", valid, 0);

        run_enum(1, 1'b0);
        check("w1_count", got_q.size(), 8);
        for (int i = 0; i < got_q.size(); i++) check("w1_pat", got_q[i], 32'(1 << i));

        weight = 4'd4; start = 1'b1;
        tick;
        start = 1'b0; ready = 1'b1;
        tick; tick;
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", valid, 0);
        check("arst_busy", busy, 0);
        check("arst_pattern", pattern, 0);
        check("arst_last", last, 0);
        check("arst_error", error, 0);
        tick;
        rst_n = 1'b1;
        tick;
        run_enum(4, 1'b0);
        check("w4_count", got_q.size(), 70);
        check("w4_first", got_q[0], 8'h0F);

        for (int w = 0; w <= 5; w++) begin
            weight5 = 3'(w); start5 = 1'b1;
            tick;
            start5 = 1'b0;
            cnt = 0; prev = -1;
            for (int c = 0; c < 40; c++) begin
                if (!valid5) break;
                check("n5_pop", $countones(pattern5), w);
                check("n5_incr", int'(pattern5) > prev, 1);
                prev = int'(pattern5);
                cnt++;
                tick;
            end
            check("n5_count", cnt, exp5[w]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
